// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pll_reset_sequencer
// Brief   : PLL lock supervision and staged mem -> periph -> cpu reset release.
// Revision: 1.0
// ============================================================================
module pll_reset_sequencer #(
   parameter int LOCK_TIMEOUT       = 1000000,
   parameter int PLL_RST_CYCLES     = 32,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGE_DELAY        = 16,
   parameter int SW_RST_CYCLES      = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       sw_reset_req,
   output logic       pll_rst,
   output logic       rst_n_mem,
   output logic       rst_n_periph,
   output logic       rst_n_cpu,
   output logic       ready,
   output logic [7:0] lock_lost_cnt
);

   typedef enum logic [2:0] {
      S_WAIT_LOCK  = 3'd0,
      S_PLL_RESET  = 3'd1,
      S_STABILIZE  = 3'd2,
      S_REL_MEM    = 3'd3,
      S_REL_PERIPH = 3'd4,
      S_RUN        = 3'd5,
      S_SW_RESET   = 3'd6
   } state_t;

   // Terminal counts: the counter restarts at 0 on entry, so a phase of N cycles ends at N-1.
   localparam logic [19:0] c_lock_timeout_last = 20'(LOCK_TIMEOUT - 1);
   localparam logic [19:0] c_pll_rst_last      = 20'(PLL_RST_CYCLES - 1);
   localparam logic [19:0] c_stable_last       = 20'(LOCK_STABLE_CYCLES - 1);
   localparam logic [19:0] c_stage_last        = 20'(STAGE_DELAY - 1);
   localparam logic [19:0] c_sw_rst_last       = 20'(SW_RST_CYCLES - 1);

   logic        r_locked_meta;
   logic        r_locked_s;
   state_t      r_state;
   logic [19:0] r_cnt;
   logic        r_pll_rst;
   logic        r_rst_n_mem;
   logic        r_rst_n_periph;
   logic        r_rst_n_cpu;
   logic        r_ready;
   logic [7:0]  r_lock_lost_cnt;

   state_t      w_next;
   logic        w_lock_lost;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_locked_meta <= 1'b0;
         r_locked_s    <= 1'b0;
      end else begin
         r_locked_meta <= pll_locked;
         r_locked_s    <= r_locked_meta;
      end
   end

   // Lock loss is tested first in every released state so it wins over requests and expiry.
   always_comb begin
      w_next      = r_state;
      w_lock_lost = 1'b0;
      case (r_state)
         S_WAIT_LOCK: begin
            if (r_locked_s)                        w_next = S_STABILIZE;
            else if (r_cnt == c_lock_timeout_last) w_next = S_PLL_RESET;
         end
         S_PLL_RESET: begin
            if (r_cnt == c_pll_rst_last) w_next = S_WAIT_LOCK;
         end
         S_STABILIZE: begin
            if (!r_locked_s)                 w_next = S_WAIT_LOCK;
            else if (r_cnt == c_stable_last) w_next = S_REL_MEM;
         end
         S_REL_MEM: begin
            if (!r_locked_s) begin
               w_next      = S_WAIT_LOCK;
               w_lock_lost = 1'b1;
            end else if (r_cnt == c_stage_last) begin
               w_next = S_REL_PERIPH;
            end
         end
         S_REL_PERIPH: begin
            if (!r_locked_s) begin
               w_next      = S_WAIT_LOCK;
               w_lock_lost = 1'b1;
            end else if (r_cnt == c_stage_last) begin
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            if (!r_locked_s) begin
               w_next      = S_WAIT_LOCK;
               w_lock_lost = 1'b1;
            end else if (sw_reset_req) begin
               w_next = S_SW_RESET;
            end
         end
         S_SW_RESET: begin
            if (!r_locked_s) begin
               w_next      = S_WAIT_LOCK;
               w_lock_lost = 1'b1;
            end else if (r_cnt == c_sw_rst_last) begin
               w_next = S_REL_MEM;
            end
         end
         default: w_next = S_WAIT_LOCK;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_WAIT_LOCK;
         r_cnt           <= 20'd0;
         r_pll_rst       <= 1'b0;
         r_rst_n_mem     <= 1'b0;
         r_rst_n_periph  <= 1'b0;
         r_rst_n_cpu     <= 1'b0;
         r_ready         <= 1'b0;
         r_lock_lost_cnt <= 8'd0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_cnt <= 20'd0;
         else if (r_state != S_RUN)
            r_cnt <= r_cnt + 20'd1;
         r_pll_rst      <= (w_next == S_PLL_RESET);
         r_rst_n_mem    <= (w_next inside {S_REL_MEM, S_REL_PERIPH, S_RUN, S_SW_RESET});
         r_rst_n_periph <= (w_next inside {S_REL_PERIPH, S_RUN});
         r_rst_n_cpu    <= (w_next == S_RUN);
         r_ready        <= (w_next == S_RUN);
         if (w_lock_lost && (r_lock_lost_cnt != 8'hFF))
            r_lock_lost_cnt <= r_lock_lost_cnt + 8'd1;
      end
   end

   assign pll_rst       = r_pll_rst;
   assign rst_n_mem     = r_rst_n_mem;
   assign rst_n_periph  = r_rst_n_periph;
   assign rst_n_cpu     = r_rst_n_cpu;
   assign ready         = r_ready;
   assign lock_lost_cnt = r_lock_lost_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pll_reset_sequencer
// Brief   : Scoreboard bench; a phase/countdown model predicts every edge.
// Revision: 1.0
// ============================================================================
module tb_pll_reset_sequencer;

   localparam int T_LOCK   = 100;
   localparam int T_PLLRST = 5;
   localparam int T_STABLE = 8;
   localparam int T_STAGE  = 4;
   localparam int T_SWRST  = 6;

   logic       clk;
   logic       rst_n;
   logic       pll_locked;
   logic       sw_reset_req;
   logic       pll_rst;
   logic       rst_n_mem;
   logic       rst_n_periph;
   logic       rst_n_cpu;
   logic       ready;
   logic [7:0] lock_lost_cnt;

   pll_reset_sequencer #(
      .LOCK_TIMEOUT      (T_LOCK),
      .PLL_RST_CYCLES    (T_PLLRST),
      .LOCK_STABLE_CYCLES(T_STABLE),
      .STAGE_DELAY       (T_STAGE),
      .SW_RST_CYCLES     (T_SWRST)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pll_locked   (pll_locked),
      .sw_reset_req (sw_reset_req),
      .pll_rst      (pll_rst),
      .rst_n_mem    (rst_n_mem),
      .rst_n_periph (rst_n_periph),
      .rst_n_cpu    (rst_n_cpu),
      .ready        (ready),
      .lock_lost_cnt(lock_lost_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [12:0] v;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   edge_idx = 0;

   // Reference model: named phase plus cycles left in it, lock seen through a 2-deep delay line.
   string m_phase = "WAIT_LOCK";
   int    m_left  = T_LOCK;
   int    m_lost  = 0;
   logic  m_s1    = 1'b0;
   logic  m_s2    = 1'b0;

   function automatic int dur(input string p);
      if (p == "WAIT_LOCK") return T_LOCK;
      if (p == "PLL_RESET") return T_PLLRST;
      if (p == "STABILIZE") return T_STABLE;
      if (p == "SW_RESET")  return T_SWRST;
      if (p == "RUN")       return 0;
      return T_STAGE;
   endfunction

   task automatic enter(input string p);
      m_phase = p;
      m_left  = dur(p);
   endtask

   task automatic tick(input string nxt);
      m_left = m_left - 1;
      if (m_left == 0) enter(nxt);
   endtask

   task automatic model_edge(input logic pl, input logic sw, input logic rn);
      logic ls;
      logic released;
      if (!rn) begin
         m_s1 = 1'b0; m_s2 = 1'b0; m_lost = 0;
         enter("WAIT_LOCK");
         return;
      end
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = pl;
      released = (m_phase == "REL_MEM") || (m_phase == "REL_PERIPH") ||
                 (m_phase == "RUN") || (m_phase == "SW_RESET");
      if (released && !ls) begin
         if (m_lost < 255) m_lost = m_lost + 1;
         enter("WAIT_LOCK");
      end else if (m_phase == "WAIT_LOCK") begin
         if (ls) enter("STABILIZE");
         else    tick("PLL_RESET");
      end else if (m_phase == "PLL_RESET") begin
         tick("WAIT_LOCK");
      end else if (m_phase == "STABILIZE") begin
         if (!ls) enter("WAIT_LOCK");
         else     tick("REL_MEM");
      end else if (m_phase == "REL_MEM") begin
         tick("REL_PERIPH");
      end else if (m_phase == "REL_PERIPH") begin
         tick("RUN");
      end else if (m_phase == "RUN") begin
         if (sw) enter("SW_RESET");
      end else begin
         tick("REL_MEM");
      end
   endtask

   function automatic logic [12:0] model_out();
      logic p, m, ph, c, r;
      p  = (m_phase == "PLL_RESET");
      m  = (m_phase == "REL_MEM") || (m_phase == "REL_PERIPH") ||
           (m_phase == "RUN") || (m_phase == "SW_RESET");
      ph = (m_phase == "REL_PERIPH") || (m_phase == "RUN");
      c  = (m_phase == "RUN");
      r  = (m_phase == "RUN");
      return {p, m, ph, c, r, 8'(m_lost)};
   endfunction

   function automatic logic [12:0] dut_out();
      return {pll_rst, rst_n_mem, rst_n_periph, rst_n_cpu, ready, lock_lost_cnt};
   endfunction

   // Drive one cycle's inputs at the falling edge and queue the prediction for the next rising edge.
   task automatic step(input logic pl, input logic sw, input logic rn);
      exp_t e;
      @(negedge clk);
      pll_locked   = pl;
      sw_reset_req = sw;
      rst_n        = rn;
      if (!rn) begin
         #1;
         checks++;
         if (dut_out() !== 13'd0) begin
            failures++;
            $display("FAIL async_reset t=%0t got=%h want=0000", $time, dut_out());
         end
      end
      model_edge(pl, sw, rn);
      edge_idx++;
      e.idx = edge_idx;
      e.v   = model_out();
      exp_q.push_back(e);
   endtask

   // Monitor: each rising edge presents a new output word; compare it with the oldest prediction.
   initial begin
      exp_t e;
      logic [12:0] got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = dut_out();
            checks++;
            if (got !== e.v) begin
               failures++;
               $display("FAIL scoreboard edge=%0d got pll_rst/mem/periph/cpu/ready=%b%b%b%b%b cnt=%0d want=%b%b%b%b%b cnt=%0d",
                        e.idx, got[12], got[11], got[10], got[9], got[8], got[7:0],
                        e.v[12], e.v[11], e.v[10], e.v[9], e.v[8], e.v[7:0]);
            end
         end
      end
   end

   initial begin
      logic pl;
      logic sw;
      logic rn;
      int   rst_hold;
      rst_n        = 1'b0;
      pll_locked   = 1'b0;
      sw_reset_req = 1'b0;

      // Locked before reset release: normal staged bring-up into RUN.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1);

      // Software reset, with extra requests during SW_RESET and REL_MEM that must be ignored.
      for (int i = 0; i < 30; i++) step(1'b1, (i == 0) || (i == 2) || (i == 8), 1'b1);

      // Lock loss reaching the FSM in the same cycle as a software request.
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1);

      // No lock at all: periodic PLL reset pulses.
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 220; i++) step(1'b0, 1'b0, 1'b1);

      // One-cycle glitch while stabilizing.
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1);

      // 300 lock losses after release: counter must saturate.
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b1);
         for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
      end
      @(posedge clk);
      #2;
      checks++;
      if (lock_lost_cnt !== 8'd255) begin
         failures++;
         $display("FAIL lock_lost_saturate got=%0d want=255", lock_lost_cnt);
      end

      // Randomized traffic with occasional mid-operation resets.
      pl       = 1'b1;
      rst_hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (pl) begin
            if ($urandom_range(149, 0) == 0) pl = 1'b0;
         end else begin
            if ($urandom_range(29, 0) == 0) pl = 1'b1;
         end
         sw = ($urandom_range(19, 0) == 0);
         if (rst_hold == 0 && $urandom_range(499, 0) == 0) rst_hold = $urandom_range(3, 1);
         rn = (rst_hold == 0);
         if (rst_hold > 0) rst_hold--;
         step(pl, sw, rn);
      end

      @(posedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain got=%0d pending want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
